// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester round-robin arbiter in front of a single
// shared memory port with a fixed, parameterised read latency.
//
// Ports
//   clk, resetn            single clock, synchronous active-low reset
//   mN_req/we/addr/wdata   requester N command (held until mN_ack)
//   mN_rdata               registered read data, updated only by N's reads
//   mN_ack                 one-cycle completion pulse
//   mem_address/data_out/we  shared memory command, non-zero only in ISSUE/WAIT
//   mem_data_in            memory read data, READ_LATENCY clocks after sampling
//
// One transaction in flight: IDLE -> ISSUE -> (WAIT ->) DONE -> IDLE.
// All memory-side and ack outputs are registered.

// Per-requester read-data holding register.
module mem_arbiter_port #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!resetn)   q_q <= '0;
    else if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module mem_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_we,
  input  logic [31:0] mem_data_in
);
  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int CW      = 3;

  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  // Requester inputs gathered into packed arrays indexed by requester id.
  logic [NUM_REQ-1:0]         req_vec, we_vec;
  logic [NUM_REQ-1:0][DW-1:0] addr_vec, wdata_vec, rdata_vec;

  assign req_vec   = {m1_req, m0_req};
  assign we_vec    = {m1_we, m0_we};
  assign addr_vec  = {m1_addr, m0_addr};
  assign wdata_vec = {m1_wdata, m0_wdata};

  state_e             state_q;
  logic               gnt_q;       // requester owning the current transaction
  logic               we_q;
  logic               prio_q;      // requester that wins the next tie
  logic [CW-1:0]      cnt_q;
  logic [DW-1:0]      mem_address_q, mem_data_out_q;
  logic               mem_we_q;
  logic [NUM_REQ-1:0] ack_q;

  // Round-robin pick: a lone requester always wins, a tie goes to prio_q.
  logic gnt_d;
  always_comb begin
    gnt_d = prio_q;
    if (req_vec == 2'b01)      gnt_d = 1'b0;
    else if (req_vec == 2'b10) gnt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      we_q           <= 1'b0;
      prio_q         <= 1'b0;
      cnt_q          <= '0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_we_q       <= 1'b0;
      ack_q          <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_vec) begin
            // The command is captured here; later input changes are ignored.
            gnt_q          <= gnt_d;
            we_q           <= we_vec[gnt_d];
            mem_address_q  <= addr_vec[gnt_d];
            mem_we_q       <= we_vec[gnt_d];
            mem_data_out_q <= we_vec[gnt_d] ? wdata_vec[gnt_d] : '0;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we_q       <= 1'b0;
          mem_data_out_q <= '0;
          if (we_q) begin
            mem_address_q <= '0;
            ack_q[gnt_q]  <= 1'b1;
            state_q       <= DONE;
          end else begin
            // Address stays on the bus for the whole read wait.
            cnt_q   <= CW'(READ_LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            mem_address_q <= '0;
            ack_q[gnt_q]  <= 1'b1;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          prio_q  <= ~gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is captured on the edge that leaves WAIT; reset in WAIT
  // suppresses the load because reset has priority in the port register.
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_port
    logic ld;
    assign ld = (state_q == WAIT) && (cnt_q == '0) && (gnt_q == 1'(n));
    mem_arbiter_port #(.DW(DW)) u_port (
      .clk    (clk),
      .resetn (resetn),
      .ld_i   (ld),
      .d_i    (mem_data_in),
      .q_o    (rdata_vec[n])
    );
  end

  assign m0_rdata     = rdata_vec[0];
  assign m1_rdata     = rdata_vec[1];
  assign m0_ack       = ack_q[0];
  assign m1_ack       = ack_q[1];
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_we       = mem_we_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The stimulus thread pushes the expected
// memory command and completion for each transaction; a monitor on the
// falling edge pops and compares whenever the memory bus or an ack shows up.
module tb_mem_arbiter;
  localparam int RL = 3;

  logic        clk = 0;
  logic        resetn = 0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_address, mem_data_out, mem_data_in;
  logic        m0_ack, m1_ack, mem_we;

  always #5 clk = ~clk;

  mem_arbiter #(.READ_LATENCY(RL)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
    .mem_data_in(mem_data_in)
  );

  // Memory model: unwritten words read as 0x5A5A0000 | word index.
  logic [31:0] memv [256];
  logic        wv [256] = '{default: 1'b0};
  logic [31:0] pipe [RL] = '{default: 32'h0};

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return wv[a[9:2]] ? memv[a[9:2]] : (32'h5A5A0000 | 32'(a[9:2]));
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mem_rd(mem_address);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    if (mem_we) begin
      memv[mem_address[9:2]] <= mem_data_out;
      wv[mem_address[9:2]]   <= 1'b1;
    end
  end
  assign mem_data_in = pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr, wdata, rdata, ordata;
    int          gap;     // required ISSUE - previous ack distance, 0 = any
  } exp_t;
  exp_t iss_q[$], ack_q[$];

  task automatic expect_txn(input int p, input bit w, input logic [31:0] a, d, rd, od,
                            input int gap, input bit acked);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = d; e.rdata = rd; e.ordata = od; e.gap = gap;
    iss_q.push_back(e);
    if (acked) ack_q.push_back(e);
  endtask

  // Monitor
  initial begin
    bit          prev_act = 0, act, cur_we = 0;
    logic [1:0]  prev_ack = 0, ackv;
    logic [31:0] cur_addr = 0, own, oth;
    int          issue_cyc = 0, last_ack_cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      ackv = {m1_ack, m0_ack};
      if (!resetn) begin
        prev_act = 0; prev_ack = 0;
      end else begin
        act = (mem_address != 0) || mem_we || (mem_data_out != 0);
        if (act && !prev_act) begin
          if (iss_q.size() == 0) chk("unexpected_issue", mem_address, 32'h0);
          else begin
            e = iss_q.pop_front();
            chk("issue_addr", mem_address, e.addr);
            chk("issue_we", 32'(mem_we), 32'(e.we));
            chk("issue_wdata", mem_data_out, e.we ? e.wdata : 32'h0);
            if (e.gap != 0) chk("idle_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
            cur_addr = e.addr; cur_we = e.we; issue_cyc = cyc;
          end
        end else if (act) begin
          chk("wait_we", 32'(mem_we), 32'h0);
          chk("wait_addr", mem_address, cur_addr);
          chk("wait_dout", mem_data_out, 32'h0);
        end
        prev_act = act;
        if (ackv != 0) begin
          chk("ack_one_cycle", 32'(prev_ack), 32'h0);
          if (ack_q.size() == 0) chk("unexpected_ack", 32'(ackv), 32'h0);
          else begin
            e = ack_q.pop_front();
            own = (e.port == 0) ? m0_rdata : m1_rdata;
            oth = (e.port == 0) ? m1_rdata : m0_rdata;
            chk("ack_port", 32'(ackv), (e.port == 0) ? 32'h1 : 32'h2);
            chk("rdata", own, e.rdata);
            chk("other_rdata", oth, e.ordata);
            chk("latency", 32'(cyc - issue_cyc), cur_we ? 32'd1 : 32'(RL + 1));
          end
          last_ack_cyc = cyc;
        end
        prev_ack = ackv;
      end
    end
  end

  task automatic drive(input int p, input bit r, input bit w, input logic [31:0] a, d);
    if (p == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
  endtask

  // Issue one request and hold it until its ack; drops req at the edge
  // ending the ack cycle. 'early' drops req and scrambles the command
  // right after the sampling edge.
  task automatic do_req(input int p, input bit w, input logic [31:0] a, d, input bit early);
    int n = 0;
    drive(p, 1, w, a, d);
    if (early) begin
      @(posedge clk); #1;
      drive(p, 0, ~w, 32'h300, 32'hFFFFFFFF);
    end
    forever begin
      @(negedge clk);
      if ((p == 0 && m0_ack) || (p == 1 && m1_ack)) break;
      if (++n > 60) begin
        chk("ack_timeout", 32'({m1_ack, m0_ack}), (p == 0) ? 32'h1 : 32'h2);
        break;
      end
    end
    @(posedge clk); #1;
    drive(p, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'h0);
    chk({tag, "_mem_addr"}, mem_address, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_dout"}, mem_data_out, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    chk_idle_outputs("reset");

    // Write, then read it back from the other port.
    expect_txn(0, 1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 0, 1);
    expect_txn(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 2, 1);
    do_req(0, 1, 32'h100, 32'hDEADBEEF, 0);
    do_req(1, 0, 32'h100, 32'h0, 0);

    // Lone requester, back-to-back reads.
    expect_txn(1, 0, 32'h104, 0, 32'h5A5A0041, 32'h0, 2, 1);
    expect_txn(1, 0, 32'h108, 0, 32'h5A5A0042, 32'h0, 2, 1);
    expect_txn(1, 0, 32'h100, 0, 32'hDEADBEEF, 32'h0, 2, 1);
    expect_txn(1, 0, 32'h200, 0, 32'h5A5A0080, 32'h0, 2, 1);
    do_req(1, 0, 32'h104, 0, 0);
    do_req(1, 0, 32'h108, 0, 0);
    do_req(1, 0, 32'h100, 0, 0);
    do_req(1, 0, 32'h200, 0, 0);

    // Early drop: request vanishes and address changes during ISSUE.
    expect_txn(0, 0, 32'h200, 0, 32'h5A5A0080, 32'h5A5A0080, 2, 1);
    do_req(0, 0, 32'h200, 0, 1);

    // Reset in the second WAIT cycle of an m0 read: no ack, rdata cleared.
    expect_txn(0, 0, 32'h104, 0, 0, 0, 2, 0);
    drive(0, 1, 0, 32'h104, 0);
    repeat (3) @(posedge clk);   // sample -> ISSUE -> WAIT1 -> WAIT2
    #1 resetn = 0;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 resetn = 1;
    chk_idle_outputs("abort");
    repeat (6) @(posedge clk);
    #1;

    // Tie from reset: grants must alternate m0, m1, m0, m1.
    expect_txn(0, 1, 32'h10C, 32'h11111111, 32'h0, 32'h0, 0, 1);
    expect_txn(1, 0, 32'h100, 0, 32'hDEADBEEF, 32'h0, 2, 1);
    expect_txn(0, 0, 32'h10C, 0, 32'h11111111, 32'hDEADBEEF, 2, 1);
    expect_txn(1, 1, 32'h110, 32'h22222222, 32'hDEADBEEF, 32'h11111111, 2, 1);
    fork
      begin do_req(0, 1, 32'h10C, 32'h11111111, 0); do_req(0, 0, 32'h10C, 0, 0); end
      begin do_req(1, 0, 32'h100, 0, 0); do_req(1, 1, 32'h110, 32'h22222222, 0); end
    join

    repeat (4) @(posedge clk);
    chk("issues_drained", 32'(iss_q.size()), 32'h0);
    chk("acks_drained", 32'(ack_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1, is the number of clocks from the memory sampling mem_address to mem_data_in being valid; legal range is 1..8, and any other value SHALL be an elaboration error.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 m0_req / m1_req  in  1  requester N access request; held high until mN_ack.
REQ-005 m0_we / m1_we  in  1  1 = write, 0 = read; valid while mN_req is high.
REQ-006 m0_addr / m1_addr  in  32  byte address.
REQ-007 m0_wdata / m1_wdata  in  32  write data.
REQ-008 m0_rdata / m1_rdata  out  32  registered read data per requester.
REQ-009 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-010 mem_address  out  32  shared memory address.
REQ-011 mem_data_out  out  32  shared memory write data.
REQ-012 mem_we  out  1  shared memory write enable.
REQ-013 mem_data_in  in  32  shared memory read data.

Function
REQ-014 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, and hold exactly one granted transaction at a time.
REQ-015 In IDLE, when any mN_req is sampled high at a posedge, the block SHALL latch that requester's id, we, addr and wdata, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a lone requester always wins; when both requests are high, the requester not granted last SHALL win; after reset, m0 SHALL win the first tie.
REQ-017 The last-granted pointer SHALL update only on the DONE->IDLE transition.
REQ-018 In ISSUE, the block SHALL drive mem_address=latched addr for exactly one cycle, and for a write also mem_we=1 and mem_data_out=latched wdata.
REQ-019 From ISSUE, a write SHALL go to DONE, and a read SHALL go to WAIT with a counter loaded to READ_LATENCY-1.
REQ-020 In WAIT, mem_address SHALL hold the latched addr and mem_we SHALL be 0; at each posedge, a counter of 0 SHALL capture mem_data_in into the granted mN_rdata and go to DONE, otherwise the counter SHALL decrement.
REQ-021 In DONE, the granted mN_ack SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 Outside ISSUE and WAIT, mem_address, mem_data_out and mem_we SHALL be 0; mem_data_out SHALL be 0 on reads.
REQ-023 Latency from the request-sampling edge to the ack cycle SHALL be: write = 2 cycles (ISSUE, DONE); read = READ_LATENCY+2 cycles.
REQ-024 Only one of m0_ack and m1_ack SHALL ever be high, and only in DONE.
REQ-025 mN_rdata SHALL change only on a completed read for port N, and SHALL hold its value across writes and across the other port's reads.
REQ-026 A requester SHALL deassert mN_req at the posedge ending its ack cycle; a req still high in the following IDLE SHALL be treated as a new request.
REQ-027 If mN_req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-028 Address and data changes on inputs after the latching edge SHALL have no effect on the current transaction.
REQ-029 The block SHALL have no back-to-back issue: at least one IDLE cycle SHALL separate transactions.

Reset
REQ-030 On resetn=0 at a posedge, the block SHALL enter IDLE, with the pointer favoring m0, counter=0, m0_rdata=m1_rdata=0, and all acks and mem_* outputs 0.
REQ-031 Reset mid-transaction (ISSUE, WAIT or DONE) SHALL abort it with no ack and no rdata update; a mem_we pulse SHALL be truncated at the reset edge.

Verification
REQ-032 Write: m0 write addr=0x100, wdata=0xDEADBEEF -> one ISSUE cycle with mem_address=0x100, mem_we=1, mem_data_out=0xDEADBEEF; m0_ack 2 cycles after the sampling edge; m0_rdata unchanged (0).
REQ-033 Read at READ_LATENCY=1 and 3: m1 read 0x100 with memory returning 0xDEADBEEF -> m1_rdata=0xDEADBEEF and m1_ack at 3 and 5 cycles respectively; mem_we=0 throughout.
REQ-034 Tie: both requests high from reset, each re-requesting immediately after ack -> grants alternate m0, m1, m0, m1; never two consecutive grants to one port while the other waits.
REQ-035 Lone requester: m1 issues 4 back-to-back reads with m0 idle -> all 4 granted to m1, each separated by exactly one IDLE cycle.
REQ-036 Reset in WAIT: m0 read at READ_LATENCY=4, resetn=0 at the second WAIT cycle -> no m0_ack, m0_rdata=0, state IDLE, next tie granted to m0.
REQ-037 Early drop: m0 read with m0_req deasserted during ISSUE and m0_addr changed -> access uses the originally latched address; m0_ack still pulses once.
